tq_side_pipe: RTL and testbench

- Parametrised sideband delay pipeline for the TQ path, carrying valid, transform size and a generic sideband word alongside a DCT/quant datapath of DEPTH stages.
- Tracks transform-block boundaries at the input and emits block-start and block-end flags aligned with the delayed valid.
- Adds pipeline-wide stall and synchronous flush, exposes every stage's valid and transize as taps, and flags illegal mid-block size changes.

---
 rtl/tq_side_pipe_if.sv | 33 +++
 rtl/tq_side_pipe.sv | 127 ++++++++++++
 tb/tb_tq_side_pipe.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tq_side_pipe_if.sv
// Sideband pipeline bus: the beat inputs and controls driven by the producer,
// plus the delayed beat, stage taps and tracker status returned by the pipe.
interface tq_side_pipe_if #(
  parameter int DEPTH = 4,
  parameter int SW    = 8
);
  logic                 i_valid;
  logic [1:0]           i_transize;
  logic [SW-1:0]        i_side;
  logic                 i_stall;
  logic                 i_flush;
  logic                 o_valid;
  logic [1:0]           o_transize;
  logic [SW-1:0]        o_side;
  logic                 o_sop;
  logic                 o_eop;
  logic [DEPTH-1:0]     o_tap_valid;
  logic [2*DEPTH-1:0]   o_tap_transize;
  logic                 o_busy;
  logic                 o_err;

  modport master (
    output i_valid, i_transize, i_side, i_stall, i_flush,
    input  o_valid, o_transize, o_side, o_sop, o_eop,
    input  o_tap_valid, o_tap_transize, o_busy, o_err
  );

  modport slave (
    input  i_valid, i_transize, i_side, i_stall, i_flush,
    output o_valid, o_transize, o_side, o_sop, o_eop,
    output o_tap_valid, o_tap_transize, o_busy, o_err
  );
endinterface

// File: rtl/tq_side_pipe.sv
// Sideband delay pipeline for the TQ path. Carries valid, transform size and a
// sideband word through DEPTH register stages, marks the first and last beat
// of every transform block, and flags size changes inside a block.
module tq_side_pipe #(
  parameter int DEPTH = 4,
  parameter int SW    = 8
) (
  input logic           clk,
  input logic           rst,
  tq_side_pipe_if.slave bus
);

  logic                 acc_s;
  logic                 blk_sop_s;
  logic                 blk_eop_s;
  logic                 size_err_s;
  logic [1:0]           beat_size_s;
  logic [4:0]           last_idx_s;
  logic [4:0]           cnt_next_s;

  logic [DEPTH-1:0]     valid_r;
  logic [DEPTH-1:0]     sop_r;
  logic [DEPTH-1:0]     eop_r;
  logic [DEPTH-1:0][1:0]    size_r;
  logic [DEPTH-1:0][SW-1:0] side_r;

  logic [4:0]           cnt_r;
  logic [1:0]           lat_size_r;
  logic                 busy_r;
  logic                 err_r;

  // Index of the last beat of a block for a given size code (4 << size, minus 1).
  function automatic logic [4:0] last_beat(input logic [1:0] size);
    logic [4:0] idx;
    case (size)
      2'd0:    idx = 5'd3;
      2'd1:    idx = 5'd7;
      2'd2:    idx = 5'd15;
      2'd3:    idx = 5'd31;
      default: idx = 5'd3;
    endcase
    return idx;
  endfunction

  // Block tracker decode: which size the incoming beat carries and where it sits in its block.
  always_comb begin
    acc_s = bus.i_valid & ~bus.i_stall & ~bus.i_flush;
    if (cnt_r == 5'd0) begin
      beat_size_s = bus.i_transize;
    end else begin
      beat_size_s = lat_size_r;
    end
    last_idx_s = last_beat(beat_size_s);
    blk_sop_s  = (cnt_r == 5'd0);
    blk_eop_s  = (cnt_r == last_idx_s);
    size_err_s = acc_s & (cnt_r != 5'd0) & (bus.i_transize != lat_size_r);
    if (!acc_s) begin
      cnt_next_s = cnt_r;
    end else if (blk_eop_s) begin
      cnt_next_s = 5'd0;
    end else begin
      cnt_next_s = cnt_r + 5'd1;
    end
  end

  // Input-side block state: beat counter, latched block size, busy and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= 5'd0;
      lat_size_r <= 2'd0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else if (bus.i_flush) begin
      cnt_r  <= 5'd0;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (acc_s) begin
      cnt_r  <= cnt_next_s;
      busy_r <= (cnt_next_s != 5'd0);
      if (cnt_r == 5'd0) begin
        lat_size_r <= bus.i_transize;
      end
      if (size_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Delay stages: shift when not stalled; flush kills every in-flight beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      sop_r   <= '0;
      eop_r   <= '0;
      size_r  <= '0;
      side_r  <= '0;
    end else if (bus.i_flush) begin
      valid_r <= '0;
      sop_r   <= '0;
      eop_r   <= '0;
    end else if (!bus.i_stall) begin
      valid_r[0] <= bus.i_valid;
      sop_r[0]   <= blk_sop_s & bus.i_valid;
      eop_r[0]   <= blk_eop_s & bus.i_valid;
      size_r[0]  <= beat_size_s;
      side_r[0]  <= bus.i_side;
      for (int k = 1; k < DEPTH; k++) begin
        valid_r[k] <= valid_r[k-1];
        sop_r[k]   <= sop_r[k-1] & valid_r[k-1];
        eop_r[k]   <= eop_r[k-1] & valid_r[k-1];
        size_r[k]  <= size_r[k-1];
        side_r[k]  <= side_r[k-1];
      end
    end
  end

  assign bus.o_valid        = valid_r[DEPTH-1];
  assign bus.o_transize     = size_r[DEPTH-1];
  assign bus.o_side         = side_r[DEPTH-1];
  assign bus.o_sop          = sop_r[DEPTH-1];
  assign bus.o_eop          = eop_r[DEPTH-1];
  assign bus.o_tap_valid    = valid_r;
  assign bus.o_tap_transize = size_r;
  assign bus.o_busy         = busy_r;
  assign bus.o_err          = err_r;

endmodule

// File: tb/tb_tq_side_pipe.sv
// Randomised and directed bench for tq_side_pipe against a beat-level
// reference model of the sideband pipe and block tracker.
module tb_tq_side_pipe;
  localparam int DEPTH = 4;
  localparam int SW    = 8;
  localparam int VW    = 7 + SW + 3 * DEPTH;
  localparam int PAD   = 64 - VW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tq_side_pipe_if #(.DEPTH(DEPTH), .SW(SW)) bus ();
  tq_side_pipe #(.DEPTH(DEPTH), .SW(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: per-stage beat records, position in block, block size, error.
  bit m_v[DEPTH];
  int m_sz[DEPTH];
  int m_sd[DEPTH];
  bit m_sop[DEPTH];
  bit m_eop[DEPTH];
  int m_idx;
  int m_blk;
  bit m_err;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0; m_sz[i] = 0; m_sd[i] = 0; m_sop[i] = 0; m_eop[i] = 0;
    end
    m_idx = 0; m_blk = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit v, int sz, int sd, bit st, bit fl);
    int s;
    bit so, eo;
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_v[i] = 0; m_sop[i] = 0; m_eop[i] = 0;
      end
      m_idx = 0; m_err = 0;
    end else if (!st) begin
      s = (m_idx == 0) ? sz : m_blk;
      so = 0; eo = 0;
      if (v) begin
        if (m_idx == 0) m_blk = sz;
        else if (sz != m_blk) m_err = 1;
        so = (m_idx == 0);
        eo = (m_idx == (4 << m_blk) - 1);
        m_idx = eo ? 0 : m_idx + 1;
      end
      for (int i = DEPTH - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_sz[i] = m_sz[i-1]; m_sd[i] = m_sd[i-1];
        m_sop[i] = m_sop[i-1]; m_eop[i] = m_eop[i-1];
      end
      m_v[0] = v; m_sz[0] = s; m_sd[0] = sd; m_sop[0] = so; m_eop[0] = eo;
    end
  endfunction

  // Expected output bundle; fields of invalid beats are zeroed.
  function automatic logic [63:0] exp_vec();
    logic [DEPTH-1:0] tv;
    logic [2*DEPTH-1:0] ts;
    bit lv;
    lv = m_v[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      tv[i] = m_v[i];
      ts[2*i +: 2] = m_v[i] ? 2'(m_sz[i]) : 2'b00;
    end
    return {{PAD{1'b0}}, lv, lv ? 2'(m_sz[DEPTH-1]) : 2'b00,
            lv ? SW'(m_sd[DEPTH-1]) : {SW{1'b0}},
            lv & m_sop[DEPTH-1], lv & m_eop[DEPTH-1], tv, ts, m_idx != 0, m_err};
  endfunction

  // Observed output bundle with the same masking applied.
  function automatic logic [63:0] obs_vec();
    logic [2*DEPTH-1:0] ts;
    logic lv;
    lv = bus.o_valid;
    for (int i = 0; i < DEPTH; i++)
      ts[2*i +: 2] = bus.o_tap_valid[i] ? bus.o_tap_transize[2*i +: 2] : 2'b00;
    return {{PAD{1'b0}}, lv, lv ? bus.o_transize : 2'b00,
            lv ? bus.o_side : {SW{1'b0}},
            lv & bus.o_sop, lv & bus.o_eop, bus.o_tap_valid, ts, bus.o_busy, bus.o_err};
  endfunction

  task automatic cycle(input bit v, input int sz, input int sd, input bit st, input bit fl);
    bus.i_valid    = v;
    bus.i_transize = 2'(sz);
    bus.i_side     = SW'(sd);
    bus.i_stall    = st;
    bus.i_flush    = fl;
    @(posedge clk);
    model_step(v, sz, sd, st, fl);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({bus.o_valid, bus.o_sop, bus.o_eop, bus.o_tap_valid, bus.o_tap_transize,
         bus.o_side, bus.o_busy, bus.o_err} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", obs_vec());
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int first = -1;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 4) cycle(1, 0, 8'h10 + c, 0, 0);
      else cycle(0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (bus.o_valid && first < 0) begin
        first = c;
        checks++;
        if (bus.o_side !== 8'h11 || bus.o_sop !== 1'b1) begin
          errors++;
          $display("FAIL basic_first side=%h sop=%b want side=11 sop=1", bus.o_side, bus.o_sop);
        end
      end
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL basic_latency got=%0d want=4", first);
    end
  endtask

  task automatic test_big_block();
    int sops = 0, eops = 0, outs = 0, eop_at = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 10) cycle(1, 3, $urandom, 0, 0);
      else if (c == 10) cycle(0, 3, 0, 0, 0);
      else if (c < 33) cycle(1, 3, $urandom, 0, 0);
      else cycle(0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL big cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (bus.o_valid) begin
        outs++;
        if (bus.o_sop) sops++;
        if (bus.o_eop) begin eops++; eop_at = outs; end
        if (bus.o_transize !== 2'd3) begin
          errors++;
          $display("FAIL big_size got=%0d want=3", bus.o_transize);
        end
      end
    end
    checks++;
    if (sops != 1 || eops != 1 || eop_at != 32 || bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL big_flags sop=%0d eop=%0d at=%0d err=%b want 1 1 32 0", sops, eops, eop_at, bus.o_err);
    end
  endtask

  task automatic test_stall();
    int first = -1;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 2) cycle(1, 1, 8'h40 + c, 0, 0);
      else if (c <= 5) cycle(1, 1, 8'h77, 1, 0);
      else cycle(0, 1, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (bus.o_valid && first < 0) first = c;
    end
    checks++;
    if (first != 7) begin
      errors++;
      $display("FAIL stall_latency got=%0d want=7", first);
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_size_change();
    for (int c = 0; c < 14; c++) begin
      if (c < 8) cycle(1, (c == 2) ? 2 : 1, 8'h50 + c, 0, 0);
      else cycle(0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sizechg cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (c == 2) begin
        checks++;
        if (bus.o_err !== 1'b1) begin
          errors++;
          $display("FAIL sizechg_err got=%b want=1", bus.o_err);
        end
      end
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (bus.o_err !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL sizechg_clear err=%b want=0", bus.o_err);
    end
  endtask

  task automatic test_flush_stall();
    for (int c = 0; c < 5; c++) cycle(1, 1, 8'h60 + c, 0, 0);
    cycle(1, 1, 8'h99, 1, 1);
    checks++;
    if (bus.o_tap_valid !== '0 || bus.o_busy !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL flush taps=%b busy=%b want 0 0", bus.o_tap_valid, bus.o_busy);
    end
    for (int c = 0; c < 8; c++) begin
      if (c < 4) cycle(1, 0, 8'h70 + c, 0, 0);
      else cycle(0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL flush_after cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) cycle(1, 0, 8'h80 + c, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.o_valid, bus.o_sop, bus.o_eop, bus.o_tap_valid, bus.o_tap_transize,
         bus.o_side, bus.o_transize, bus.o_busy, bus.o_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid got=%h want=0", obs_vec());
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) cycle(1, 0, 8'h90 + c, 0, 0);
      else cycle(0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_after cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int sz = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) sz = $urandom_range(3);
      cycle($urandom_range(3) != 0, sz, $urandom, $urandom_range(7) == 0,
            $urandom_range(59) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_transize = 2'd0; bus.i_side = '0;
    bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_big_block();
    test_stall();
    test_size_change();
    test_flush_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
